// File: rtl/streebog_pkg.sv
// Shared types and constants for the Streebog message sequencer.
// Build option STREEBOG_CTRL_ADD_PIPE_EN (used by streebog_add512) is not referenced here.
package streebog_pkg;

    localparam int unsigned DATA_WIDTH = 512;
    localparam int unsigned LEN_W      = 10;
    localparam int unsigned BLK_BITS   = 512;
    localparam int unsigned HALF_W     = DATA_WIDTH / 2;

    localparam logic [DATA_WIDTH-1:0] IV512 = '0;
    localparam logic [DATA_WIDTH-1:0] IV256 = {64{8'h01}};

    typedef enum logic [3:0] {
        StIdle,
        StWaitBlk,
        StCall,
        StWaitG,
        StUpd,
        StPadCall,
        StFinN,
        StFinS,
        StDone
    } state_t;

    // Which call is in flight, so WAIT_G knows where to go next.
    typedef enum logic [1:0] {
        PhBlk,
        PhFinN,
        PhFinS
    } phase_t;

endpackage

// File: rtl/streebog_add512.sv
// Mod-2^512 adder used for the N and Sigma updates.
// Default: single-cycle combinational add, done follows start in the same cycle.
// STREEBOG_CTRL_ADD_PIPE_EN: low half and carry are registered in the first cycle,
// the upper half is summed from registered operands in the second; done arrives one
// cycle later. start must be held until done.
module streebog_add512
    import streebog_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  done
);

`ifdef STREEBOG_CTRL_ADD_PIPE_EN
    logic [HALF_W:0]   lo_full;
    logic [HALF_W-1:0] lo_q;
    logic [HALF_W-1:0] a_hi_q;
    logic [HALF_W-1:0] b_hi_q;
    logic              carry_q;
    logic              valid_q;
    logic              take;

    // First stage: low-half add with carry out; accept only when not already holding a result
    always_comb begin
        take    = start & ~valid_q;
        lo_full = {1'b0, a[HALF_W-1:0]} + {1'b0, b[HALF_W-1:0]};
    end

    // Stage registers; valid drops once the result has been presented for a cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lo_q    <= '0;
            a_hi_q  <= '0;
            b_hi_q  <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= take;
            if (take) begin
                lo_q    <= lo_full[HALF_W-1:0];
                carry_q <= lo_full[HALF_W];
                a_hi_q  <= a[DATA_WIDTH-1:HALF_W];
                b_hi_q  <= b[DATA_WIDTH-1:HALF_W];
            end
        end
    end

    // Second stage: upper half with the registered carry
    always_comb begin
        sum  = {a_hi_q + b_hi_q + HALF_W'(carry_q), lo_q};
        done = valid_q;
    end
`else
    logic unused_clk_rstn;
    assign unused_clk_rstn = clk ^ rstn;

    // Plain full-width add, result valid in the cycle it is requested
    always_comb begin
        sum  = a + b;
        done = start;
    end
`endif

endmodule

// File: rtl/streebog_ctrl.sv
// Streebog (GOST R 34.11-2012) message sequencer around a single g_function core.
// Holds h, N and Sigma, pads the final block, then issues g_0(h,N) and g_0(h,Sigma).
// Build option STREEBOG_CTRL_ADD_PIPE_EN: pipelined N/Sigma adders (UPD takes 2 cycles).
module streebog_ctrl
    import streebog_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  mode256_i,
    input  logic                  blk_valid_i,
    output logic                  blk_ready_o,
    input  logic [DATA_WIDTH-1:0] blk_data_i,
    input  logic                  blk_last_i,
    input  logic [LEN_W-1:0]      blk_bits_i,
    output logic [DATA_WIDTH-1:0] g_n_o,
    output logic [DATA_WIDTH-1:0] g_m_o,
    output logic [DATA_WIDTH-1:0] g_h_o,
    output logic                  g_valid_o,
    input  logic [DATA_WIDTH-1:0] g_hash_i,
    input  logic                  g_hash_valid_i,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] hash_o,
    output logic                  hash_valid_o
);

    state_t                state_q, state_d;
    phase_t                phase_q;
    logic [DATA_WIDTH-1:0] h_q, n_q, sigma_q;
    logic [DATA_WIDTH-1:0] g_n_q, g_m_q, g_h_q, hash_q;
    logic [LEN_W-1:0]      len_q;
    logic                  last_q, full_q, mode256_q, busy_q, hash_valid_q;

    logic [LEN_W-1:0]      blk_len;
    logic                  blk_full;
    logic [DATA_WIDTH-1:0] pad_bit, blk_m;
    logic [DATA_WIDTH-1:0] n_addend, n_sum, sigma_sum;
    logic                  add_start, n_done, s_done, add_done;

    // Final-block padding: clamp length, keep L data bits, set bit L, zero above
    always_comb begin
        blk_len  = (blk_bits_i > LEN_W'(BLK_BITS)) ? LEN_W'(BLK_BITS) : blk_bits_i;
        blk_full = ~blk_last_i | (blk_len == LEN_W'(BLK_BITS));
        pad_bit  = DATA_WIDTH'(1) << blk_len;
        blk_m    = blk_full ? blk_data_i : ((blk_data_i & (pad_bit - DATA_WIDTH'(1))) | pad_bit);
        n_addend = {{(DATA_WIDTH - LEN_W){1'b0}}, len_q};
        add_done = n_done & s_done;
    end

    streebog_add512 u_add_n (
        .clk   (clk_i),
        .rstn  (rstn_i),
        .start (add_start),
        .a     (n_q),
        .b     (n_addend),
        .sum   (n_sum),
        .done  (n_done)
    );

    // Sigma accumulates the m operand that is still held on g_m_o
    streebog_add512 u_add_s (
        .clk   (clk_i),
        .rstn  (rstn_i),
        .start (add_start),
        .a     (sigma_q),
        .b     (g_m_q),
        .sum   (sigma_sum),
        .done  (s_done)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and adder request
    always_comb begin
        state_d   = state_q;
        add_start = 1'b0;
        unique case (state_q)
            StIdle:    if (start_i) state_d = StWaitBlk;
            StWaitBlk: if (blk_valid_i) state_d = StCall;
            StCall:    state_d = StWaitG;
            StWaitG: begin
                if (g_hash_valid_i) begin
                    unique case (phase_q)
                        PhBlk:   state_d = StUpd;
                        PhFinN:  state_d = StFinS;
                        default: state_d = StDone;
                    endcase
                end
            end
            StUpd: begin
                add_start = 1'b1;
                if (add_done) begin
                    if (!last_q)     state_d = StWaitBlk;
                    else if (full_q) state_d = StPadCall;
                    else             state_d = StFinN;
                end
            end
            StPadCall, StFinN, StFinS: state_d = StCall;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Chaining state, call operands and digest output
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            phase_q      <= PhBlk;
            h_q          <= '0;
            n_q          <= '0;
            sigma_q      <= '0;
            g_n_q        <= '0;
            g_m_q        <= '0;
            g_h_q        <= '0;
            hash_q       <= '0;
            len_q        <= '0;
            last_q       <= 1'b0;
            full_q       <= 1'b0;
            mode256_q    <= 1'b0;
            busy_q       <= 1'b0;
            hash_valid_q <= 1'b0;
        end else begin
            hash_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        h_q       <= mode256_i ? IV256 : IV512;
                        n_q       <= '0;
                        sigma_q   <= '0;
                        hash_q    <= '0;
                        mode256_q <= mode256_i;
                        busy_q    <= 1'b1;
                    end
                end
                StWaitBlk: begin
                    if (blk_valid_i) begin
                        g_n_q   <= n_q;
                        g_h_q   <= h_q;
                        g_m_q   <= blk_m;
                        len_q   <= blk_full ? LEN_W'(BLK_BITS) : blk_len;
                        last_q  <= blk_last_i;
                        full_q  <= blk_full;
                        phase_q <= PhBlk;
                    end
                end
                StWaitG: if (g_hash_valid_i) h_q <= g_hash_i;
                StUpd: begin
                    if (add_done) begin
                        n_q     <= n_sum;
                        sigma_q <= sigma_sum;
                    end
                end
                // A 512-bit final block is followed by an empty padded block (m = 1, L = 0)
                StPadCall: begin
                    g_n_q   <= n_q;
                    g_h_q   <= h_q;
                    g_m_q   <= DATA_WIDTH'(1);
                    len_q   <= '0;
                    full_q  <= 1'b0;
                    phase_q <= PhBlk;
                end
                StFinN: begin
                    g_n_q   <= '0;
                    g_h_q   <= h_q;
                    g_m_q   <= n_q;
                    phase_q <= PhFinN;
                end
                StFinS: begin
                    g_n_q   <= '0;
                    g_h_q   <= h_q;
                    g_m_q   <= sigma_q;
                    phase_q <= PhFinS;
                end
                StDone: begin
                    hash_q       <= mode256_q ? {{HALF_W{1'b0}}, h_q[DATA_WIDTH-1:HALF_W]} : h_q;
                    hash_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign blk_ready_o  = (state_q == StWaitBlk);
    assign g_valid_o    = (state_q == StCall);
    assign g_n_o        = g_n_q;
    assign g_m_o        = g_m_q;
    assign g_h_o        = g_h_q;
    assign busy_o       = busy_q;
    assign hash_o       = hash_q;
    assign hash_valid_o = hash_valid_q;

endmodule

// File: tb/tb_streebog_ctrl.sv
// Bench for streebog_ctrl. g_function is replaced by a deterministic surrogate mixing
// function; expected digests come from a sequencing model built on the same surrogate.
module tb_streebog_ctrl;

    logic         clk = 1'b0;
    logic         rstn_i, start_i, mode256_i, blk_valid_i, blk_last_i;
    logic [9:0]   blk_bits_i;
    logic [511:0] blk_data_i;
    logic [511:0] g_hash_i = '0;
    logic         g_hash_valid_i = 1'b0;
    logic         blk_ready_o, g_valid_o, busy_o, hash_valid_o;
    logic [511:0] g_n_o, g_m_o, g_h_o, hash_o;

    int nvec = 0;
    int nmis = 0;
    int nhv  = 0;

    logic [511:0] exp_q[$];
    logic [511:0] last_hash = '0;
    logic [511:0] call_n[$], call_m[$], call_h[$];
    logic [511:0] msg[4];

    int           g_lat = 2;
    int           g_cnt = 0;
    logic         g_pend = 1'b0;
    logic         prev_gv = 1'b0;
    logic [511:0] cap_n, cap_m, cap_h;

    streebog_ctrl dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .start_i        (start_i),
        .mode256_i      (mode256_i),
        .blk_valid_i    (blk_valid_i),
        .blk_ready_o    (blk_ready_o),
        .blk_data_i     (blk_data_i),
        .blk_last_i     (blk_last_i),
        .blk_bits_i     (blk_bits_i),
        .g_n_o          (g_n_o),
        .g_m_o          (g_m_o),
        .g_h_o          (g_h_o),
        .g_valid_o      (g_valid_o),
        .g_hash_i       (g_hash_i),
        .g_hash_valid_i (g_hash_valid_i),
        .busy_o         (busy_o),
        .hash_o         (hash_o),
        .hash_valid_o   (hash_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Surrogate compression: nonlinear, depends on every bit of N, h and m
    function automatic logic [511:0] gsim(input logic [511:0] n, input logic [511:0] h,
                                          input logic [511:0] m);
        logic [511:0] t;
        t = h ^ m;
        t = t + {n[200:0], n[511:201]} + 512'h5a;
        t = t ^ (t << 13) ^ (t >> 7);
        t = t * {8{64'h9e3779b97f4a7c15}};
        return t ^ h ^ {m[255:0], m[511:256]};
    endfunction

    // Reference sequencing of a message held in msg[0..nblk-1]
    function automatic logic [511:0] ref_hash(input int nblk, input int bits, input bit m256);
        logic [511:0] h, n, s, m, src;
        int l;
        h = m256 ? {64{8'h01}} : '0;
        n = '0;
        s = '0;
        for (int b = 0; b < nblk - 1; b++) begin
            h = gsim(n, h, msg[b]);
            n = n + 512'd512;
            s = s + msg[b];
        end
        src = msg[nblk-1];
        l = (bits > 512) ? 512 : bits;
        if (l == 512) begin
            h = gsim(n, h, src);
            n = n + 512'd512;
            s = s + src;
            l = 0;
        end
        m = '0;
        for (int i = 0; i < l; i++) m[i] = src[i];
        m[l] = 1'b1;
        h = gsim(n, h, m);
        n = n + 512'(l);
        s = s + m;
        h = gsim('0, h, n);
        h = gsim('0, h, s);
        return m256 ? {256'b0, h[511:256]} : h;
    endfunction

    // g_function stand-in with programmable latency; also logs every call
    always @(negedge clk) begin
        g_hash_valid_i = 1'b0;
        if (g_pend) begin
            check("blk_ready_during_call", 512'(blk_ready_o), 512'd0);
            if (g_cnt == 0) begin
                if (busy_o) begin
                    check("op_m_stable", g_m_o, cap_m);
                    check("op_h_stable", g_h_o, cap_h);
                end
                g_hash_i       = gsim(cap_n, cap_h, cap_m);
                g_hash_valid_i = 1'b1;
                g_pend         = 1'b0;
            end else begin
                g_cnt--;
            end
        end
        if (g_valid_o) begin
            check("single_call_outstanding", 512'({g_pend, prev_gv}), 512'd0);
            cap_n = g_n_o;
            cap_m = g_m_o;
            cap_h = g_h_o;
            call_n.push_back(g_n_o);
            call_m.push_back(g_m_o);
            call_h.push_back(g_h_o);
            g_pend = 1'b1;
            g_cnt  = g_lat;
        end
        prev_gv = g_valid_o;
    end

    // Scoreboard: each digest strobe pops one expectation
    always @(negedge clk) begin
        if (hash_valid_o) begin
            nhv++;
            last_hash = hash_o;
            check("hash_expected", 512'(exp_q.size() != 0), 512'd1);
            if (exp_q.size() != 0) check("hash", hash_o, exp_q.pop_front());
        end
    end

    task automatic clear_log();
        call_n.delete();
        call_m.delete();
        call_h.delete();
    endtask

    task automatic send_msg(input int nblk, input int bits, input bit m256, input bit noisy);
        int t;
        int hv0;
        exp_q.push_back(ref_hash(nblk, bits, m256));
        hv0 = nhv;
        @(negedge clk);
        start_i   = 1'b1;
        mode256_i = m256;
        @(negedge clk);
        start_i   = 1'b0;
        mode256_i = noisy ? ~m256 : m256;
        for (int b = 0; b < nblk; b++) begin
            blk_data_i  = msg[b];
            blk_last_i  = (b == nblk - 1);
            blk_bits_i  = 10'(bits);
            blk_valid_i = 1'b1;
            start_i     = noisy;
            t = 0;
            while (!blk_ready_o && t < 300) begin
                @(negedge clk);
                t++;
            end
            check("blk_accept_timeout", 512'(t < 300), 512'd1);
            @(negedge clk);
        end
        blk_valid_i = 1'b0;
        start_i     = 1'b0;
        t = 0;
        while (nhv == hv0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("hash_timeout", 512'(t < 2000), 512'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] exp_m;
        int t;
        int hv0;
        rstn_i      = 1'b0;
        start_i     = 1'b0;
        mode256_i   = 1'b0;
        blk_valid_i = 1'b0;
        blk_last_i  = 1'b0;
        blk_bits_i  = '0;
        blk_data_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_blk_ready", 512'(blk_ready_o), 512'd0);
        check("rst_busy", 512'(busy_o), 512'd0);
        check("rst_g_valid", 512'(g_valid_o), 512'd0);
        check("rst_hash_valid", 512'(hash_valid_o), 512'd0);
        check("rst_hash", hash_o, '0);
        check("rst_g_n", g_n_o, '0);
        check("rst_g_m", g_m_o, '0);
        check("rst_g_h", g_h_o, '0);
        rstn_i = 1'b1;

        // M1: 63 ASCII digits, first character in the least significant byte
        msg[0] = '0;
        for (int i = 0; i < 63; i++) msg[0][8*i +: 8] = 8'(8'h30 + i % 10);
        exp_m = msg[0];
        exp_m[504] = 1'b1;

        clear_log();
        g_lat = 2;
        send_msg(1, 504, 1'b0, 1'b0);
        check("m1_calls", 512'(call_m.size()), 512'd3);
        check("m1_c0_n", call_n[0], '0);
        check("m1_c0_h_iv512", call_h[0], '0);
        check("m1_c0_m_padded", call_m[0], exp_m);
        check("m1_finn_m", call_m[1], 512'd504);
        check("m1_finn_n", call_n[1], '0);
        check("m1_fins_m", call_m[2], exp_m);

        clear_log();
        g_lat = 3;
        send_msg(1, 504, 1'b1, 1'b0);
        check("m256_c0_h_iv256", call_h[0], {64{8'h01}});
        check("m256_upper_zero", {256'b0, last_hash[511:256]}, '0);

        // Full final block: extra padding call with m = 1
        for (int k = 0; k < 16; k++) msg[0][32*k +: 32] = $urandom();
        clear_log();
        g_lat = 1;
        send_msg(1, 512, 1'b0, 1'b0);
        check("full_calls", 512'(call_m.size()), 512'd4);
        check("full_pad_m", call_m[1], 512'd1);
        check("full_pad_n", call_n[1], 512'd512);
        check("full_final_n", call_m[2], 512'd512);
        check("full_fins_sigma", call_m[3], msg[0] + 512'd1);

        // Over-range bit count behaves as 512
        clear_log();
        send_msg(1, 700, 1'b0, 1'b0);
        check("clamp_calls", 512'(call_m.size()), 512'd4);

        // Empty message: data bits ignored, m = 1
        clear_log();
        g_lat = 2;
        send_msg(1, 0, 1'b0, 1'b0);
        check("empty_calls", 512'(call_m.size()), 512'd3);
        check("empty_c0_m", call_m[0], 512'd1);
        check("empty_c0_n", call_n[0], '0);
        check("empty_finn_m", call_m[1], '0);
        check("empty_fins_m", call_m[2], 512'd1);

        // Back-to-back multi-block messages with start_i and mode256_i toggling while busy
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 16; k++) msg[b][32*k +: 32] = $urandom();
        hv0 = nhv;
        clear_log();
        g_lat = 5;
        send_msg(3, 100, 1'b1, 1'b1);
        check("b2b_a_calls", 512'(call_m.size()), 512'd5);
        check("b2b_a_c2_n", call_n[2], 512'd1024);
        clear_log();
        g_lat = 2;
        send_msg(2, 512, 1'b0, 1'b1);
        check("b2b_b_calls", 512'(call_m.size()), 512'd5);
        check("b2b_hash_pulses", 512'(nhv - hv0), 512'd2);
        check("b2b_scoreboard_empty", 512'(exp_q.size()), 512'd0);

        // Reset while waiting on g_function
        msg[0] = '0;
        for (int i = 0; i < 63; i++) msg[0][8*i +: 8] = 8'(8'h30 + i % 10);
        clear_log();
        g_lat = 8;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        blk_data_i  = msg[0];
        blk_last_i  = 1'b1;
        blk_bits_i  = 10'd504;
        blk_valid_i = 1'b1;
        @(negedge clk);
        blk_valid_i = 1'b0;
        t = 0;
        while (call_m.size() == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort_call_timeout", 512'(t < 50), 512'd1);
        repeat (2) @(negedge clk);
        rstn_i = 1'b0;
        hv0 = nhv;
        @(negedge clk);
        check("abort_busy", 512'(busy_o), 512'd0);
        check("abort_blk_ready", 512'(blk_ready_o), 512'd0);
        check("abort_g_valid", 512'(g_valid_o), 512'd0);
        check("abort_g_m", g_m_o, '0);
        check("abort_g_h", g_h_o, '0);
        check("abort_hash", hash_o, '0);
        rstn_i = 1'b1;
        repeat (12) @(negedge clk);
        check("stray_busy", 512'(busy_o), 512'd0);
        check("stray_blk_ready", 512'(blk_ready_o), 512'd0);
        check("stray_no_hash", 512'(nhv - hv0), 512'd0);
        g_lat = 2;
        send_msg(1, 504, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("final_scoreboard_empty", 512'(exp_q.size()), 512'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
